// File: rtl/risky_mmio_pkg.sv
// Purpose: shared constants for the risky core MMIO console (region code, register map, TX_CTRL bits).
// Latency: n/a (constants and a pure status-packing function only).
// Backpressure: n/a.
package risky_mmio_pkg;

    // Upper address bits [31:26] that select the console region.
    localparam logic [5:0] MMIO_REGION = 6'd2;

    // Register indices, taken from mem_addr[3:0].
    localparam logic [3:0] IDX_EXIT      = 4'd0;
    localparam logic [3:0] IDX_EXIT_CODE = 4'd1;
    localparam logic [3:0] IDX_TX_DATA   = 4'd2;
    localparam logic [3:0] IDX_TX_CTRL   = 4'd3;
    localparam logic [3:0] IDX_RX_DATA   = 4'd4;
    localparam logic [3:0] IDX_RX_CTRL   = 4'd5;

    // TX_CTRL bit positions: status on read, overflow-clear command on write.
    localparam int TXC_FULL_BIT    = 0;
    localparam int TXC_EMPTY_BIT   = 1;
    localparam int TXC_OVF_BIT     = 2;
    localparam int TXC_CLR_OVF_BIT = 31;

    function automatic logic [31:0] tx_ctrl_status(input logic ovf, input logic empty,
                                                   input logic full);
        logic [31:0] v;
        v                = '0;
        v[TXC_FULL_BIT]  = full;
        v[TXC_EMPTY_BIT] = empty;
        v[TXC_OVF_BIT]   = ovf;
        return v;
    endfunction

endpackage

// File: rtl/risky_sync_fifo.sv
// Purpose: single-clock FIFO, power-of-two DEPTH, head word always visible on pop_data.
// Latency: a push is visible on empty/pop_data the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
// Ports: clk/rst (async active-high), push/push_data, pop/pop_data, full, empty, count.
module risky_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still take the push.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/risky_mmio_console.sv
// Purpose: MMIO console for the risky core: exit/halt, exit code, byte TX FIFO, single-byte RX.
// Latency: reads are combinational on mem_data; writes land at the clk edge; TX byte valid the cycle after push.
// Backpressure: tx_ready stalls the TX FIFO (overflow flag on drop); rx_ready only while software has a request pending.
// Ports: clk, rst (async active-high), mem_addr/mem_data/mem_oe/mem_we core bus,
//        tx_data/tx_valid/tx_ready byte sink, rx_data/rx_valid/rx_ready byte source, halt, exit_code.
module risky_mmio_console
    import risky_mmio_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic        mem_oe,
    input  logic        mem_we,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          sel;
    logic          wr_en;
    logic [3:0]    idx;
    logic [31:0]   rd_data;
    logic [7:0]    tx_hold;
    logic [7:0]    rx_byte;
    logic          rx_pending;
    logic          overflow;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign sel      = (mem_addr[31:26] == MMIO_REGION);
    assign idx      = mem_addr[3:0];
    assign wr_en    = mem_we & sel;
    assign tx_valid = ~fifo_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_ready = rx_pending;

    // TX_CTRL write: bit 31 is a pure overflow clear; any other nonzero value is a push.
    assign tx_clr  = wr_en & (idx == IDX_TX_CTRL) & mem_data[TXC_CLR_OVF_BIT];
    assign tx_push = wr_en & (idx == IDX_TX_CTRL) & ~mem_data[TXC_CLR_OVF_BIT]
                   & (mem_data != '0);

    // Bus stays released during reset so the core sees nothing stale.
    assign mem_data = (mem_oe & sel & ~rst) ? rd_data : 'z;

    always_comb begin
        rd_data = '0;
        case (idx)
            IDX_EXIT:      rd_data = {31'b0, halt};
            IDX_EXIT_CODE: rd_data = exit_code;
            IDX_TX_DATA:   rd_data = {24'b0, tx_hold};
            IDX_TX_CTRL:   rd_data = tx_ctrl_status(overflow, fifo_empty, fifo_full);
            IDX_RX_DATA:   rd_data = {24'b0, rx_byte};
            IDX_RX_CTRL:   rd_data = {31'b0, rx_pending};
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt       <= 1'b0;
            exit_code  <= '0;
            tx_hold    <= '0;
            rx_byte    <= '0;
            rx_pending <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en && idx == IDX_EXIT && mem_data != '0) halt <= 1'b1;
            if (wr_en && idx == IDX_EXIT_CODE)              exit_code <= mem_data;
            if (wr_en && idx == IDX_TX_DATA)                tx_hold <= mem_data[7:0];

            // A push that finds the FIFO full with no simultaneous pop is lost.
            if (tx_clr)
                overflow <= 1'b0;
            else if (tx_push && fifo_full && !tx_pop)
                overflow <= 1'b1;

            // A byte arriving on the same edge as an RX_CTRL write takes priority.
            if (rx_valid && rx_pending) begin
                rx_byte    <= rx_data;
                rx_pending <= 1'b0;
            end else if (wr_en && idx == IDX_RX_CTRL) begin
                rx_pending <= (mem_data != '0);
            end
        end
    end

    risky_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_hold),
        .pop       (tx_pop),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign unused_bits = ^{mem_addr[25:4], fifo_count};

endmodule

// File: tb/tb_risky_mmio_console.sv
module tb_risky_mmio_console;

    localparam int D = 8;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic [31:0] exit_code;

    logic [31:0] cpu_dat;
    logic        cpu_drv;

    int checks = 0;
    int errors = 0;

    // Bus: bench drives on writes; pull-ups make a released bus read all ones.
    assign mem_data = cpu_drv ? cpu_dat : 32'hz;
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (mem_data[g]);
    end

    risky_mmio_console #(.TX_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .halt      (halt),
        .exit_code (exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    logic        m_ovf, m_pend, m_halt;
    logic [7:0]  m_txh, m_rx;
    logic [31:0] m_exit;
    logic        m_sel, m_pop, m_full;
    logic [3:0]  m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_pend = 0; m_halt = 0; m_txh = 0; m_rx = 0; m_exit = 0;
        end else begin
            m_sel  = mem_we && (mem_addr[31:26] == 6'd2);
            m_idx  = mem_addr[3:0];
            m_full = (m_q.size() == D);
            m_pop  = (m_q.size() != 0) && tx_ready;
            if (m_pop) void'(m_q.pop_front());
            if (m_sel && m_idx == 3) begin
                if (cpu_dat[31]) m_ovf = 0;
                else if (cpu_dat != 0) begin
                    if (!m_full || m_pop) m_q.push_back(m_txh);
                    else m_ovf = 1;
                end
            end
            if (m_sel && m_idx == 0 && cpu_dat != 0) m_halt = 1;
            if (m_sel && m_idx == 1) m_exit = cpu_dat;
            if (m_sel && m_idx == 2) m_txh = cpu_dat[7:0];
            if (rx_valid && m_pend) begin
                m_rx = rx_data; m_pend = 0;
            end else if (m_sel && m_idx == 5) m_pend = (cpu_dat != 0);
        end
    end

    function automatic logic [31:0] mread(input logic [3:0] i);
        case (i)
            4'd0: return {31'b0, m_halt};
            4'd1: return m_exit;
            4'd2: return {24'b0, m_txh};
            4'd3: return {29'b0, m_ovf, m_q.size() == 0, m_q.size() == D};
            4'd4: return {24'b0, m_rx};
            4'd5: return {31'b0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] i, input logic [31:0] d);
        @(negedge clk);
        mem_addr = {6'd2, 22'($urandom), i};
        cpu_dat  = d;
        cpu_drv  = 1;
        mem_we   = 1;
        @(posedge clk);
        #1;
        mem_we  = 0;
        cpu_drv = 0;
    endtask

    task automatic rd(input logic [5:0] region, input logic [3:0] i, output logic [31:0] v);
        @(negedge clk);
        mem_addr = {region, 22'($urandom), i};
        mem_oe   = 1;
        #1;
        v      = mem_data;
        mem_oe = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr(4'd2, {24'b0, b});
        wr(4'd3, 32'd1);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] b);
        @(negedge clk);
        chk({name, "_vld"}, {31'b0, tx_valid}, 32'd1);
        chk({name, "_dat"}, {24'b0, tx_data}, {24'b0, b});
        tx_ready = 1;
        @(posedge clk);
        #1;
        tx_ready = 0;
    endtask

    task automatic check_outputs();
        chk("rnd_tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) chk("rnd_tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
        chk("rnd_rx_ready", {31'b0, rx_ready}, {31'b0, m_pend});
        chk("rnd_halt", {31'b0, halt}, {31'b0, m_halt});
        chk("rnd_exit_code", exit_code, m_exit);
    endtask

    typedef struct {
        logic [3:0]  widx;
        logic [31:0] wdat;
        logic [3:0]  ridx;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] v;

    initial begin
        rst = 1; mem_addr = 0; mem_oe = 0; mem_we = 0; cpu_dat = 0; cpu_drv = 0;
        tx_ready = 0; rx_data = 0; rx_valid = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("rst_halt", {31'b0, halt}, 32'd0);
        chk("rst_exit_code", exit_code, 32'd0);
        mem_addr = {6'd2, 22'd0, 4'd3};
        mem_oe   = 1;
        #1;
        chk("rst_bus_released", mem_data, 32'hFFFF_FFFF);
        mem_oe = 0;
        @(negedge clk);
        rst = 0;
        rd(6'd2, 4'd3, v); chk("post_rst_txctrl", v, 32'd2);
        rd(6'd2, 4'd4, v); chk("post_rst_rxdata", v, 32'd0);

        // Table of register write/read pairs
        vecs[0]  = '{4'd1,  32'hDEAD_BEEF, 4'd1,  32'hDEAD_BEEF};
        vecs[1]  = '{4'd2,  32'h1234_5678, 4'd2,  32'h0000_0078};
        vecs[2]  = '{4'd4,  32'h0000_00FF, 4'd4,  32'h0000_0000};
        vecs[3]  = '{4'd6,  32'hFFFF_FFFF, 4'd6,  32'h0000_0000};
        vecs[4]  = '{4'd15, 32'h0000_0001, 4'd15, 32'h0000_0000};
        vecs[5]  = '{4'd5,  32'h0000_0001, 4'd5,  32'h0000_0001};
        vecs[6]  = '{4'd5,  32'h0000_0000, 4'd5,  32'h0000_0000};
        vecs[7]  = '{4'd3,  32'h0000_0000, 4'd3,  32'h0000_0002};
        vecs[8]  = '{4'd0,  32'h0000_0000, 4'd0,  32'h0000_0000};
        vecs[9]  = '{4'd1,  32'h0000_0000, 4'd1,  32'h0000_0000};
        vecs[10] = '{4'd2,  32'h0000_00AB, 4'd2,  32'h0000_00AB};
        vecs[11] = '{4'd3,  32'h8000_0000, 4'd3,  32'h0000_0002};
        for (int i = 0; i < 12; i++) begin
            wr(vecs[i].widx, vecs[i].wdat);
            rd(6'd2, vecs[i].ridx, v);
            chk($sformatf("table_%0d", i), v, vecs[i].exp);
        end

        // Single byte through to the sink
        tx_ready = 1;
        wr(4'd2, 32'h41);
        wr(4'd3, 32'd1);
        chk("tx1_valid_next", {31'b0, tx_valid}, 32'd1);
        chk("tx1_data", {24'b0, tx_data}, 32'h41);
        @(posedge clk);
        #1;
        chk("tx1_drained", {31'b0, tx_valid}, 32'd0);
        tx_ready = 0;
        rd(6'd2, 4'd3, v); chk("tx1_ctrl", v, 32'd2);

        // Overflow: nine pushes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) push_byte(8'h30 + 8'(i));
        rd(6'd2, 4'd3, v); chk("ovf_ctrl", v, 32'd5);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'h30 + 8'(i));
        @(negedge clk);
        chk("ovf_empty", {31'b0, tx_valid}, 32'd0);
        wr(4'd3, 32'h8000_0000);
        rd(6'd2, 4'd3, v); chk("ovf_cleared", v, 32'd2);

        // Full FIFO, push and pop on the same edge
        for (int i = 0; i < 8; i++) push_byte(8'h60 + 8'(i));
        wr(4'd2, 32'h55);
        @(negedge clk);
        mem_addr = {6'd2, 22'd0, 4'd3};
        cpu_dat = 32'd1; cpu_drv = 1; mem_we = 1; tx_ready = 1;
        @(posedge clk);
        #1;
        mem_we = 0; cpu_drv = 0; tx_ready = 0;
        rd(6'd2, 4'd3, v); chk("fullpp_ctrl", v, 32'd1);
        for (int i = 1; i < 8; i++) pop_expect($sformatf("fullpp_pop%0d", i), 8'h60 + 8'(i));
        pop_expect("fullpp_last", 8'h55);
        rd(6'd2, 4'd3, v); chk("fullpp_end_ctrl", v, 32'd2);

        // RX request / capture
        wr(4'd5, 32'd1);
        chk("rx_ready_set", {31'b0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1; rx_data = 8'h7A;
        @(posedge clk);
        #1;
        rx_valid = 0;
        chk("rx_ready_clr", {31'b0, rx_ready}, 32'd0);
        rd(6'd2, 4'd5, v); chk("rx_ctrl_clr", v, 32'd0);
        rd(6'd2, 4'd4, v); chk("rx_data_7a", v, 32'h7A);
        @(negedge clk);
        rx_valid = 1; rx_data = 8'h11;
        @(posedge clk);
        #1;
        rx_valid = 0;
        rd(6'd2, 4'd4, v); chk("rx_no_pending", v, 32'h7A);
        // Capture beats an RX_CTRL write on the same edge
        wr(4'd5, 32'd1);
        @(negedge clk);
        mem_addr = {6'd2, 22'd0, 4'd5};
        cpu_dat = 32'd1; cpu_drv = 1; mem_we = 1; rx_valid = 1; rx_data = 8'h3C;
        @(posedge clk);
        #1;
        mem_we = 0; cpu_drv = 0; rx_valid = 0;
        rd(6'd2, 4'd5, v); chk("rx_race_pending", v, 32'd0);
        rd(6'd2, 4'd4, v); chk("rx_race_data", v, 32'h3C);

        // Exit / halt
        wr(4'd1, 32'd42);
        wr(4'd0, 32'd1);
        chk("halt_set", {31'b0, halt}, 32'd1);
        chk("exit_code_42", exit_code, 32'd42);
        wr(4'd0, 32'd0);
        chk("halt_sticky", {31'b0, halt}, 32'd1);
        rd(6'd2, 4'd0, v); chk("exit_read", v, 32'd1);
        wr(4'd1, 32'd7);
        chk("exit_code_after_halt", exit_code, 32'd7);
        @(negedge clk);
        rst = 1;
        #1;
        chk("halt_rst", {31'b0, halt}, 32'd0);
        chk("exit_code_rst", exit_code, 32'd0);
        @(negedge clk);
        rst = 0;

        // Region decode and address bits above the index ignored
        wr(4'd1, 32'h1234);
        rd(6'd1, 4'd1, v); chk("region1_hiz", v, 32'hFFFF_FFFF);
        rd(6'd0, 4'd1, v); chk("region0_hiz", v, 32'hFFFF_FFFF);
        rd(6'd2, 4'd1, v); chk("region2_read", v, 32'h1234);
        @(negedge clk);
        mem_addr = {6'd1, 22'd0, 4'd1};
        cpu_dat = 32'h9999; cpu_drv = 1; mem_we = 1;
        @(posedge clk);
        #1;
        mem_we = 0; cpu_drv = 0;
        chk("region1_write_ignored", exit_code, 32'h1234);

        // Reset in the middle of traffic
        wr(4'd5, 32'd1);
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        chk("mid_tx_valid", {31'b0, tx_valid}, 32'd1);
        @(negedge clk);
        rx_valid = 1; rx_data = 8'h99; rst = 1;
        #1;
        chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("mid_rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        @(negedge clk);
        rst = 0; rx_valid = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_flushed", {31'b0, tx_valid}, 32'd0);
        rd(6'd2, 4'd4, v); chk("mid_rst_no_capture", v, 32'd0);
        rd(6'd2, 4'd3, v); chk("mid_rst_ctrl", v, 32'd2);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [5:0]  region;
            logic [3:0]  i;
            logic [31:0] d;
            int          op;
            @(negedge clk);
            mem_we = 0; cpu_drv = 0;
            check_outputs();
            op     = $urandom_range(0, 3);
            i      = ($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom_range(0, 7));
            region = ($urandom_range(0, 7) == 0) ? 6'd1 : 6'd2;
            mem_addr = {region, 22'($urandom), i};
            if (op == 0) begin
                mem_oe = 1;
                #1;
                chk($sformatf("rnd_read_idx%0d", i), mem_data,
                    (region == 6'd2) ? mread(i) : 32'hFFFF_FFFF);
                mem_oe = 0;
            end else if (op == 1) begin
                case (i)
                    4'd3: case ($urandom_range(0, 4))
                              0: d = 32'd0;
                              1: d = 32'h8000_0000;
                              2: d = $urandom;
                              default: d = 32'd1;
                          endcase
                    4'd5: d = 32'($urandom_range(0, 1));
                    default: d = $urandom;
                endcase
                cpu_dat = d; cpu_drv = 1; mem_we = 1;
            end
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        mem_we = 0; cpu_drv = 0;
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risky_mmio_console.md
RISKY_MMIO_CONSOLE -- requirements
Module: risky_mmio_console

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, TX FIFO depth in bytes (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_addr  input  32  word address from the risky core.
REQ-005 SHALL have port mem_data  inout  32  shared tri-state data bus.
REQ-006 SHALL have port mem_oe  input  1  core read strobe.
REQ-007 SHALL have port mem_we  input  1  core write strobe.
REQ-008 SHALL have port tx_data  output  8  head byte of TX FIFO.
REQ-009 SHALL have port tx_valid  output  1  TX FIFO non-empty.
REQ-010 SHALL have port tx_ready  input  1  sink accepts tx_data this cycle.
REQ-011 SHALL have port rx_data  input  8  byte from host console.
REQ-012 SHALL have port rx_valid  input  1  rx_data valid.
REQ-013 SHALL have port rx_ready  output  1  block requests a byte.
REQ-014 SHALL have port halt  output  1  application has signalled exit.
REQ-015 SHALL have port exit_code  output  32  value of EXIT_CODE register.

Function
REQ-016 Selection: sel = (mem_addr[31:26] == 6'd2); register index = mem_addr[3:0]; mem_addr[25:4] ignored.
REQ-017 Reads: mem_data driven combinationally with selected register when mem_oe & sel, else high-Z; zero-latency.
REQ-018 Writes: take effect at the rising clk edge where mem_we & sel; at most one register per edge.
REQ-019 Index 0 EXIT: write of nonzero sets halt (sticky until reset); read returns {31'b0, halt}.
REQ-020 Index 1 EXIT_CODE: 32-bit read/write; drives exit_code; writable after halt.
REQ-021 Index 2 TX_DATA: 8-bit read/write holding register; bits [31:8] read 0.
REQ-022 Index 3 TX_CTRL write: data[31]=1 clears overflow, no push; else data!=0 pushes TX_DATA[7:0]; data==0 no effect.
REQ-023 Index 3 TX_CTRL read: {29'b0, overflow, empty, full}; software writes 1 then polls for bit0==0.
REQ-024 Push accepted when count<TX_DEPTH, or when full and pop occurs same edge (count unchanged); otherwise byte dropped, overflow set.
REQ-025 Pop on tx_valid & tx_ready; tx_data = head, valid same cycle as non-empty; FIFO order preserved; pointers wrap modulo TX_DEPTH.
REQ-026 Push into empty FIFO: tx_valid asserts the cycle after the write edge.
REQ-027 Index 4 RX_DATA: read-only {24'b0, last captured byte}; writes ignored.
REQ-028 Index 5 RX_CTRL write nonzero sets rx_pending; write 0 clears it; read returns {31'b0, rx_pending}.
REQ-029 rx_ready = rx_pending; on rx_valid & rx_ready edge: RX_DATA <= rx_data, rx_pending <= 0; rx_valid without pending ignored.
REQ-030 RX_CTRL write and rx capture on same edge: capture wins, pending cleared.
REQ-031 Indices 6..15 read 0, writes ignored.

Reset
REQ-032 While rst high: halt=0, exit_code=0, TX_DATA=0, RX_DATA=0, rx_pending=0, overflow=0, FIFO empty, tx_valid=0, rx_ready=0, mem_data high-Z.
REQ-033 Reset mid-transfer SHALL flush FIFO contents and abandon pending RX without capturing rx_data.

Structure
REQ-034 Package risky_mmio_pkg SHALL hold MMIO region code 6'd2, register indices 0..5, TX_CTRL bit positions.
REQ-035 TX FIFO SHALL be sub-module risky_sync_fifo (parameterised width/depth, push/pop/full/empty/count, async reset).

Verification
REQ-036 Write 0x41 to idx2, 1 to idx3, tx_ready=1 -> tx_valid one cycle after, tx_data=0x41, then empty; idx3 reads 0b010.
REQ-037 tx_ready=0, push 9 bytes 0x30..0x38 -> idx3 reads 0b101; drain yields 0x30..0x37, 0x38 lost; write 0x8000_0000 to idx3 -> 0b010.
REQ-038 FIFO full, push 0x55 with tx_ready=1 same edge -> push accepted, overflow stays 0, 0x55 emerges last.
REQ-039 Write 1 to idx5 -> rx_ready=1; drive rx_valid with 0x7A -> idx5 reads 0, idx4 reads 0x7A; rx_valid with no pending leaves idx4 unchanged.
REQ-040 Write 42 to idx1, 1 to idx0 -> halt=1, exit_code=42; write 0 to idx0 -> halt stays 1; rst pulse -> halt=0.
REQ-041 Read with mem_addr[31:26]=1 or 0 -> mem_data high-Z from this block; 3 bytes queued then async rst -> tx_valid=0 immediately.
